bus_datapath_seq: RTL and testbench



---
 rtl/bus_datapath_seq.sv | 153 +++++++++++++++
 tb/tb_bus_datapath_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bus_datapath_seq.sv
// rtl/bus_datapath_seq.sv - register file, Y/Z staging, HI/LO and ALU on one bus
// A three-state sequencer runs one three-address ALU instruction per start/done handshake.
module bus_datapath_seq #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int SH_W     = 5
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic [ADDR_W-1:0] rc,
    input  logic              ba_mode,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    typedef enum logic [1:0] {IDLE, T_A, T_B, T_WB} state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_SHRA = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_ROR  = 4'd7;
    localparam logic [3:0] OP_ROL  = 4'd8;
    localparam logic [3:0] OP_NEG  = 4'd9;
    localparam logic [3:0] OP_NOT  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    state_t            state;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [3:0]        opReg;
    logic [ADDR_W-1:0] raReg, rbReg, rcReg;
    logic              baReg;
    logic [DATA_W-1:0] yReg, zHi, zLo;
    logic [DATA_W-1:0] busVal, aluHi, aluLo;
    logic [SH_W-1:0]   shAmt;
    logic [2*DATA_W-1:0] dblShr, dblShl, product;
    logic              isReserved;

    assign rd_data    = regs[rd_addr];
    assign isReserved = (opReg > OP_MUL);

    always_comb begin
        busVal = '0;
        case (state)
            T_A:     busVal = (baReg && rbReg == '0) ? '0 : regs[rbReg];
            T_B:     busVal = regs[rcReg];
            default: busVal = '0;
        endcase
    end

    // Rotates come from shifting a doubled copy of A; MUL sign-extends both operands to 2*DATA_W.
    assign shAmt   = busVal[SH_W-1:0];
    assign dblShr  = {yReg, yReg} >> shAmt;
    assign dblShl  = {yReg, yReg} << shAmt;
    assign product = $signed({{DATA_W{yReg[DATA_W-1]}}, yReg}) *
                     $signed({{DATA_W{busVal[DATA_W-1]}}, busVal});

    always_comb begin
        aluHi = '0;
        aluLo = '0;
        case (opReg)
            OP_ADD:  aluLo = yReg + busVal;
            OP_SUB:  aluLo = yReg - busVal;
            OP_AND:  aluLo = yReg & busVal;
            OP_OR:   aluLo = yReg | busVal;
            OP_SHR:  aluLo = yReg >> shAmt;
            OP_SHRA: aluLo = $signed(yReg) >>> shAmt;
            OP_SHL:  aluLo = yReg << shAmt;
            OP_ROR:  aluLo = dblShr[DATA_W-1:0];
            OP_ROL:  aluLo = dblShl[2*DATA_W-1:DATA_W];
            OP_NEG:  aluLo = '0 - busVal;
            OP_NOT:  aluLo = ~busVal;
            OP_MUL:  {aluHi, aluLo} = product;
            default: aluLo = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            state  <= IDLE;
            opReg  <= '0;
            raReg  <= '0;
            rbReg  <= '0;
            rcReg  <= '0;
            baReg  <= 1'b0;
            yReg   <= '0;
            zHi    <= '0;
            zLo    <= '0;
            hi     <= '0;
            lo     <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A load in the accept cycle lands before T_A reads the file.
                    if (ld_en) regs[ld_addr] <= ld_data;
                    if (start) begin
                        opReg <= opcode;
                        raReg <= ra;
                        rbReg <= rb;
                        rcReg <= rc;
                        baReg <= ba_mode;
                        busy  <= 1'b1;
                        state <= T_A;
                    end
                end
                T_A: begin
                    yReg  <= busVal;
                    state <= T_B;
                end
                T_B: begin
                    zHi   <= aluHi;
                    zLo   <= aluLo;
                    state <= T_WB;
                end
                T_WB: begin
                    if (!isReserved) begin
                        if (opReg == OP_MUL) begin
                            hi <= zHi;
                            lo <= zLo;
                        end else begin
                            regs[raReg] <= zLo;
                        end
                        result <= zLo;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_datapath_seq.sv
// tb/tb_bus_datapath_seq.sv - directed bench for bus_datapath_seq
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
module tb_bus_datapath_seq;
    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  opcode = '0;
    logic [3:0]  ra = '0, rb = '0, rc = '0;
    logic        ba_mode = 1'b0;
    logic        ld_en = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [3:0]  rd_addr = '0;
    logic [31:0] rd_data, result, hi, lo;
    logic        busy, done;

    int passCnt = 0;
    int totalCnt = 0;

    bus_datapath_seq dut (
        .clk(clk), .clr(clr), .start(start), .opcode(opcode),
        .ra(ra), .rb(rb), .rc(rc), .ba_mode(ba_mode),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
        .result(result), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic checkReg(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        rd_addr = addr;
        #1;
        check(tag, rd_data, exp);
    endtask

    task automatic loadReg(input logic [3:0] addr, input logic [31:0] data);
        ld_en = 1'b1;
        ld_addr = addr;
        ld_data = data;
        tick();
        ld_en = 1'b0;
    endtask

    // Returns in the cycle where done must be high; the caller may start again right away.
    task automatic runOp(input string tag, input logic [3:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] c, input logic ba);
        start = 1'b1;
        opcode = op;
        ra = a;
        rb = b;
        rc = c;
        ba_mode = ba;
        tick();
        start = 1'b0;
        ld_en = 1'b0;
        opcode = 4'd3;
        ra = 4'd15;
        rb = 4'd15;
        rc = 4'd15;
        ba_mode = ~ba;
        for (int k = 1; k <= 2; k++) begin
            check({tag, " busy mid"}, {31'd0, busy}, 32'd1);
            check({tag, " done mid"}, {31'd0, done}, 32'd0);
            tick();
        end
        check({tag, " busy mid"}, {31'd0, busy}, 32'd1);
        tick();
        check({tag, " done at N+3"}, {31'd0, done}, 32'd1);
        check({tag, " busy at N+3"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);

        // Abort mid ADD after T_A: no writeback, everything cleared.
        loadReg(4'd2, 32'h5);
        loadReg(4'd4, 32'h6);
        start = 1'b1; opcode = 4'd0; ra = 4'd5; rb = 4'd2; rc = 4'd4; ba_mode = 1'b0;
        tick();
        start = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            check("abort done", {31'd0, done}, 32'd0);
            tick();
        end
        for (int r = 0; r < 16; r++) checkReg("abort regs", r[3:0], 32'h0);
        check("abort hi", hi, 32'h0);
        check("abort lo", lo, 32'h0);
        check("abort result", result, 32'h0);

        // ADD latency and value.
        loadReg(4'd2, 32'h0000_0034);
        loadReg(4'd4, 32'h0000_0045);
        runOp("add", 4'd0, 4'd5, 4'd2, 4'd4, 1'b0);
        checkReg("add R5", 4'd5, 32'h0000_0079);
        check("add result", result, 32'h0000_0079);

        // Shifts, rotates, negation.
        loadReg(4'd2, 32'h8000_00F1);
        loadReg(4'd4, 32'h0000_0004);
        runOp("shra", 4'd5, 4'd7, 4'd2, 4'd4, 1'b0);
        checkReg("shra R7", 4'd7, 32'hF800_000F);
        runOp("rol", 4'd8, 4'd8, 4'd2, 4'd4, 1'b0);
        checkReg("rol R8", 4'd8, 32'h0000_0F18);
        runOp("ror", 4'd7, 4'd9, 4'd2, 4'd4, 1'b0);
        checkReg("ror R9", 4'd9, 32'h1800_000F);
        runOp("shr", 4'd4, 4'd9, 4'd2, 4'd4, 1'b0);
        checkReg("shr R9", 4'd9, 32'h0800_000F);
        runOp("shl", 4'd6, 4'd9, 4'd2, 4'd4, 1'b0);
        checkReg("shl R9", 4'd9, 32'h0000_0F10);
        loadReg(4'd4, 32'h0000_0001);
        runOp("neg", 4'd9, 4'd10, 4'd2, 4'd4, 1'b0);
        checkReg("neg R10", 4'd10, 32'hFFFF_FFFF);
        runOp("not", 4'd10, 4'd10, 4'd2, 4'd4, 1'b0);
        checkReg("not R10", 4'd10, 32'hFFFF_FFFE);
        runOp("sub", 4'd1, 4'd10, 4'd2, 4'd4, 1'b0);
        checkReg("sub R10", 4'd10, 32'h8000_00F0);

        // Signed MUL writes HI/LO only.
        loadReg(4'd2, 32'hFFFF_FFFE);
        loadReg(4'd4, 32'h0000_0003);
        loadReg(4'd11, 32'h0000_AAAA);
        runOp("mul", 4'd11, 4'd11, 4'd2, 4'd4, 1'b0);
        check("mul hi", hi, 32'hFFFF_FFFF);
        check("mul lo", lo, 32'hFFFF_FFFA);
        check("mul result", result, 32'hFFFF_FFFA);
        checkReg("mul R11 kept", 4'd11, 32'h0000_AAAA);

        // Base-address mode masks R0 reads only.
        loadReg(4'd0, 32'h0000_1234);
        loadReg(4'd3, 32'h0000_0010);
        runOp("ba1", 4'd0, 4'd6, 4'd0, 4'd3, 1'b1);
        checkReg("ba1 R6", 4'd6, 32'h0000_0010);
        runOp("ba0", 4'd0, 4'd6, 4'd0, 4'd3, 1'b0);
        checkReg("ba0 R6", 4'd6, 32'h0000_1244);

        // start and ld_en while busy are ignored.
        start = 1'b1; opcode = 4'd0; ra = 4'd12; rb = 4'd3; rc = 4'd3; ba_mode = 1'b0;
        tick();
        ra = 4'd13;
        ld_en = 1'b1; ld_addr = 4'd14; ld_data = 32'h0000_DEAD;
        tick();
        tick();
        tick();
        start = 1'b0;
        ld_en = 1'b0;
        check("busy-ign done", {31'd0, done}, 32'd1);
        checkReg("busy-ign R12", 4'd12, 32'h0000_0020);
        checkReg("busy-ign R13", 4'd13, 32'h0);
        checkReg("busy-ign R14", 4'd14, 32'h0);
        tick();
        check("busy-ign no queue", {31'd0, busy}, 32'd0);

        // Load and start in the same IDLE cycle.
        ld_en = 1'b1; ld_addr = 4'd1; ld_data = 32'h7;
        runOp("ld+start", 4'd0, 4'd1, 4'd1, 4'd1, 1'b0);
        checkReg("ld+start R1", 4'd1, 32'h0000_000E);

        // Back-to-back: second start in the done cycle.
        runOp("b2b first", 4'd0, 4'd2, 4'd1, 4'd1, 1'b0);
        runOp("b2b second", 4'd1, 4'd3, 4'd2, 4'd1, 1'b0);
        checkReg("b2b R2", 4'd2, 32'h0000_001C);
        checkReg("b2b R3", 4'd3, 32'h0000_000E);

        // Reserved opcode is a full-latency NOP.
        runOp("rsvd", 4'd13, 4'd5, 4'd2, 4'd4, 1'b0);
        checkReg("rsvd R5", 4'd5, 32'h0000_0079);
        check("rsvd hi", hi, 32'hFFFF_FFFF);
        check("rsvd lo", lo, 32'hFFFF_FFFA);
        check("rsvd result", result, 32'h0000_000E);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
